// File: rtl/display_scan_mux.sv
`timescale 1ns/1ps
// display_scan_mux: time-multiplexed hex display scanner.
// Walks one digit slot per 2**PRESCALE_LOG2 clocks, most significant digit first.
// Digit data is captured into shadow registers once per frame so that a frame
// never shows a mix of old and new values. Brightness is applied as a duty gate
// on the top bits of the cycle counter. Leading zeros can optionally be blanked.
module display_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_LOG2 = 10,
    parameter int BRIGHT_W      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [3:0]                digit,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      dp,
    output logic                      frame_tick
);

    localparam int                SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    logic [PRESCALE_LOG2-1:0] r_cnt;
    logic [SLOT_W-1:0]        r_slot;
    logic [4*NUM_DIGITS-1:0]  r_data_sh;
    logic [NUM_DIGITS-1:0]    r_dp_sh;
    logic                     r_blank_sh;
    logic                     r_loaded;
    logic                     r_frame_tick;

    logic                     w_cnt_wrap;
    logic                     w_frame_end;
    logic                     w_load;
    logic                     w_duty_on;
    logic                     w_zero_run;
    logic [NUM_DIGITS-1:0]    w_blank;

    assign w_cnt_wrap  = &r_cnt;
    assign w_frame_end = w_cnt_wrap && (r_slot == LAST_SLOT);
    // The very first enabled edge after reset also loads, so the display never
    // shows the all-zero reset shadows.
    assign w_load      = enable && (w_frame_end || !r_loaded);
    assign w_duty_on   = (r_cnt[PRESCALE_LOG2-1 -: BRIGHT_W] <= brightness);
    assign frame_tick  = r_frame_tick;

    // Cycle and slot counters; both freeze while the scan is disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
            end
        end
    end

    // Shadow capture at frame boundaries plus the one-cycle frame marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_sh    <= '0;
            r_dp_sh      <= '0;
            r_blank_sh   <= 1'b0;
            r_loaded     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_load;
            if (w_load) begin
                r_data_sh  <= data;
                r_dp_sh    <= dp_in;
                r_blank_sh <= blank_lz;
                r_loaded   <= 1'b1;
            end
        end
    end

    // Leading-zero mask: a digit is blanked while every digit above it (and itself) is zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_data_sh[4*k +: 4] == 4'd0);
            if (k > 0) begin
                w_blank[k] = r_blank_sh && w_zero_run;
            end
        end
    end

    // Drive the single active digit; r_loaded keeps the display dark until
    // valid shadows exist, which also makes reset force all outputs dark.
    always_comb begin
        anode = '1;
        digit = 4'd0;
        dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_loaded && enable && w_duty_on && !w_blank[k] &&
                (int'(r_slot) == NUM_DIGITS - 1 - k)) begin
                anode[k] = 1'b0;
                digit    = r_data_sh[4*k +: 4];
                dp       = r_dp_sh[k];
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
`timescale 1ns/1ps
// Testbench for display_scan_mux: a frame-position reference model predicts the
// outputs of every cycle; predictions are queued and a negedge monitor compares.
module tb_display_scan_mux;

    localparam int ND    = 4;
    localparam int PL    = 2;
    localparam int BW    = 2;
    localparam int FRAME = ND * (1 << PL);

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [4*ND-1:0]   data;
    logic [ND-1:0]     dp_in;
    logic              blank_lz;
    logic [BW-1:0]     brightness;
    logic [3:0]        digit;
    logic [ND-1:0]     anode;
    logic              dp;
    logic              frame_tick;

    typedef struct packed {
        logic [ND-1:0] anode;
        logic [3:0]    digit;
        logic          dp;
        logic          ft;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    // Reference model: position within the frame plus the captured frame contents.
    int              m_pos;
    bit              m_loaded;
    logic [4*ND-1:0] m_data;
    logic [ND-1:0]   m_dp;
    bit              m_blank;
    bit              m_ft;

    always #5 clk = ~clk;

    display_scan_mux #(
        .NUM_DIGITS   (ND),
        .PRESCALE_LOG2(PL),
        .BRIGHT_W     (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .data      (data),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .digit     (digit),
        .anode     (anode),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    function automatic void model_reset();
        m_pos    = 0;
        m_loaded = 0;
        m_data   = '0;
        m_dp     = '0;
        m_blank  = 0;
        m_ft     = 0;
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        m_ft = 0;
        if (enable) begin
            if (!m_loaded || m_pos == FRAME - 1) begin
                m_data   = data;
                m_dp     = dp_in;
                m_blank  = blank_lz;
                m_loaded = 1;
                m_ft     = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   slot;
        int   cnt;
        int   k;
        bit   blanked;
        bit   lit;
        slot    = m_pos / (1 << PL);
        cnt     = m_pos % (1 << PL);
        k       = ND - 1 - slot;
        blanked = m_blank && (k > 0) && ((m_data >> (4 * k)) == 0);
        lit     = enable && m_loaded && !blanked && ((cnt >> (PL - BW)) <= int'(brightness));
        e.anode = '1;
        e.digit = 4'd0;
        e.dp    = 1'b0;
        if (lit) begin
            e.anode[k] = 1'b0;
            e.digit    = m_data[4*k +: 4];
            e.dp       = m_dp[k];
        end
        e.ft = m_ft;
        return e;
    endfunction

    task automatic step(input logic en, input logic [4*ND-1:0] d, input logic [ND-1:0] p,
                        input logic b, input logic [BW-1:0] br);
        @(posedge clk);
        model_edge();
        #1;
        enable     = en;
        data       = d;
        dp_in      = p;
        blank_lz   = b;
        brightness = br;
        sb.push_back(model_out());
    endtask

    // Reset is asserted between clock edges; the same cycle must already be dark.
    task automatic async_reset(input int hold);
        @(posedge clk);
        model_edge();
        #3;
        reset = 1'b0;
        model_reset();
        sb.push_back(model_out());
        repeat (hold) step(enable, data, dp_in, blank_lz, brightness);
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b1;
        sb.push_back(model_out());
    endtask

    // Monitor: every cycle with a pending prediction is checked mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({anode, digit, dp, frame_tick} !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t: got anode=%b digit=%h dp=%b ft=%b, expected anode=%b digit=%h dp=%b ft=%b",
                         phase, $time, anode, digit, dp, frame_tick, e.anode, e.digit, e.dp, e.ft);
            end
        end
    end

    initial begin
        logic [4*ND-1:0] rd;
        logic [ND-1:0]   rp;
        logic            rb;
        logic [BW-1:0]   rbr;

        reset = 1'b0; enable = 1'b0; data = '0; dp_in = '0; blank_lz = 1'b0; brightness = '0;
        model_reset();
        repeat (3) step(1'b1, 16'h1234, 4'b1111, 1'b0, 2'd3);
        reset = 1'b1;

        phase = "full_bright";
        repeat (40) step(1'b1, 16'h1234, 4'b0000, 1'b0, 2'd3);

        phase = "dim_dp";
        repeat (32) step(1'b1, 16'h1234, 4'b0100, 1'b0, 2'd0);

        phase = "blank_lz";
        repeat (32) step(1'b1, 16'h0040, 4'b0000, 1'b1, 2'd3);
        repeat (32) step(1'b1, 16'h0000, 4'b0000, 1'b1, 2'd3);

        phase = "shadow";
        repeat (8)  step(1'b1, 16'h1234, 4'b0000, 1'b0, 2'd3);
        repeat (40) step(1'b1, 16'hABCD, 4'b0000, 1'b0, 2'd3);

        phase = "enable";
        repeat (6)  step(1'b1, 16'hABCD, 4'b0001, 1'b0, 2'd2);
        repeat (5)  step(1'b0, 16'h5678, 4'b0001, 1'b0, 2'd2);
        repeat (24) step(1'b1, 16'h5678, 4'b0001, 1'b0, 2'd2);

        phase = "async_reset";
        repeat (5) step(1'b1, 16'h9E0F, 4'b1010, 1'b0, 2'd3);
        async_reset(3);
        repeat (24) step(1'b1, 16'h2468, 4'b1010, 1'b0, 2'd3);

        phase = "random";
        rd = 16'h1234; rp = '0; rb = 1'b0; rbr = 2'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset(int'($urandom_range(1, 4)));
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    rd = 16'($urandom);
                    rd = rd >> (4 * $urandom_range(0, 4));
                    rp = ND'($urandom);
                end
                if ($urandom_range(0, 15) == 0) rb  = 1'($urandom);
                if ($urandom_range(0, 9) == 0)  rbr = BW'($urandom);
                step($urandom_range(0, 9) != 0, rd, rp, rb, rbr);
            end
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
